// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Smallest binary width able to hold 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_chk.sv
// Invariant checks for bcd2bin_seq: clean final BCD residue, err/bin_out/busy relations.
module bcd2bin_seq_chk
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input logic                          clk,
  input logic                          rst_n,
  input logic                          in_done,
  input logic                          err_next,
  input logic [BCD_DIGIT_W*DIGITS-1:0] bcd_reg,
  input logic                          done,
  input logic                          busy,
  input logic                          err,
  input logic [BIN_W-1:0]              bin_out
);

  localparam int MIN_W = min_bin_w(DIGITS);

  a_width_ok: assert property (@(posedge clk) disable iff (!rst_n) (BIN_W >= MIN_W));

  // A valid operand must be fully drained out of the BCD half by the last shift.
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (in_done && !err_next) |-> (bcd_reg == '0));

  a_err_zero: assert property (@(posedge clk) disable iff (!rst_n) err |-> (bin_out == '0));

  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);

endmodule

// File: rtl/bcd_digit_corr.sv
// One-digit correction step of reverse double-dabble: subtract 3 from digits >= 8.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  // Correct a digit that picked up a carried-in weight of 8 instead of 5.
  always_comb begin
    if (digit >= 4'd8) begin
      corrected = digit - 4'd3;
    end else begin
      corrected = digit;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock)
// with a start/busy/done handshake.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_r;
  logic [BCD_W-1:0]   bcd_reg_r;
  logic [BIN_W-1:0]   bin_reg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               err_next_r;
  logic               busy_r;
  logic               done_r;
  logic [BIN_W-1:0]   bin_out_r;
  logic               err_r;

  logic [BCD_W+BIN_W-1:0] shifted_s;
  logic [BCD_W-1:0]       bcd_corr_s;
  logic                   in_valid_s;

  assign shifted_s = {1'b0, bcd_reg_r, bin_reg_r[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit     (shifted_s[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (bcd_corr_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag an operand containing any non-decimal digit.
  always_comb begin
    in_valid_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        in_valid_s = 1'b0;
      end else begin
        in_valid_s = in_valid_s;
      end
    end
  end

  // Control FSM, shift register and registered outputs. The cycle after DONE carries
  // the done pulse with busy still high; start is accepted again on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bcd_reg_r  <= '0;
      bin_reg_r  <= '0;
      cnt_r      <= '0;
      err_next_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bin_out_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          busy_r <= start;
          if (start) begin
            bcd_reg_r  <= bcd_in;
            bin_reg_r  <= '0;
            cnt_r      <= '0;
            err_next_r <= !in_valid_s;
            state_r    <= in_valid_s ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          done_r    <= 1'b0;
          busy_r    <= 1'b1;
          bcd_reg_r <= bcd_corr_s;
          bin_reg_r <= shifted_s[BIN_W-1:0];
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(BIN_W - 1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r    <= 1'b1;
          busy_r    <= 1'b1;
          bin_out_r <= err_next_r ? '0 : bin_reg_r;
          err_r     <= err_next_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_out_r;
  assign err     = err_r;

  bcd2bin_seq_chk #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_done  (state_r == ST_DONE),
    .err_next (err_next_r),
    .bcd_reg  (bcd_reg_r),
    .done     (done_r),
    .busy     (busy_r),
    .err      (err_r),
    .bin_out  (bin_out_r)
  );

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: scoreboard of expected {err, bin} per accepted operand.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  logic [10:0] sb[$];
  int          n_vec;
  int          n_fail;

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ref_conv(input logic [11:0] b);
    logic [3:0] d2, d1, d0;
    d2 = b[11:8];
    d1 = b[7:4];
    d0 = b[3:0];
    if (d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9) return {1'b1, 10'd0};
    return {1'b0, 10'(int'(d2) * 100 + int'(d1) * 10 + int'(d0))};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one start pulse, push the expectation, wait for done. lat = edges after accept, -1 on timeout.
  task automatic run_one(input logic [11:0] b, output int lat, output logic busy_ok);
    int m;
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    sb.push_back(ref_conv(b));
    @(negedge clk);
    start   = 1'b0;
    bcd_in  = ~b;
    busy_ok = 1'b1;
    m = 0;
    while (!done && m < 30) begin
      busy_ok = busy_ok & busy;
      @(negedge clk);
      m++;
    end
    busy_ok = busy_ok & busy;
    lat = done ? m : -1;
  endtask

  task automatic check_result(input string name);
    logic [10:0] exp;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: done seen with empty scoreboard", name);
    end else begin
      exp = sb.pop_front();
      if ({err, bin_out} !== exp) begin
        n_fail++;
        $display("FAIL %s: got err=%0b bin=%0d, expected err=%0b bin=%0d",
                 name, err, bin_out, exp[10], exp[9:0]);
      end
    end
  endtask

  task automatic test_reset();
    #7;
    n_vec++;
    if ({busy, done, err, bin_out} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b done=%0b err=%0b bin=%0d, expected all 0", busy, done, err, bin_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_conversion();
    int lat;
    logic bok;
    run_one(12'h999, lat, bok);
    n_vec++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL lat_999: got %0d edges, expected 11", lat);
    end
    n_vec++;
    if (bok !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_999: busy dropped during conversion, expected constant 1");
    end
    check_result("conv_999");
    @(negedge clk);
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%0b busy=%0b, expected 0 0", done, busy);
    end
    run_one(12'h000, lat, bok);
    check_result("conv_000");
    run_one(12'h409, lat, bok);
    n_vec++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL lat_409: got %0d edges, expected 11", lat);
    end
    check_result("conv_409");
  endtask

  task automatic test_invalid();
    int lat;
    logic bok;
    run_one(12'h1A5, lat, bok);
    n_vec++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL lat_1a5: got %0d edges, expected 1", lat);
    end
    check_result("conv_1a5");
    run_one(12'h125, lat, bok);
    check_result("conv_125_after_err");
  endtask

  task automatic test_start_while_busy();
    int lat, n_done;
    logic bok;
    @(negedge clk);
    bcd_in = 12'h512;
    start  = 1'b1;
    sb.push_back(ref_conv(12'h512));
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c < 30; c++) begin
      if (c == 4) begin
        bcd_in = 12'h777;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        check_result("conv_512_ignore_restart");
      end
      @(negedge clk);
    end
    n_vec++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL single_done: got %0d done pulses, expected 1", n_done);
    end
    run_one(12'h777, lat, bok);
    check_result("conv_777_fresh");
  endtask

  task automatic test_reset_abort();
    int n_done;
    @(negedge clk);
    bcd_in = 12'h256;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, bin_out} !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_async: got busy=%0b done=%0b bin=%0d, expected all 0", busy, done, bin_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_vec++;
    if (n_done !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d done pulses busy=%0b, expected 0 and 0", n_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int m;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = to_bcd(0);
    sb.push_back(ref_conv(bcd_in));
    for (int v = 0; v < 1000; v++) begin
      m = 0;
      do begin
        @(negedge clk);
        m++;
      end while (!done && m < 20);
      n_vec++;
      if (m !== 12) begin
        n_fail++;
        $display("FAIL b2b_period: value %0d got %0d cycles, expected 12", v, m);
      end
      if (!done) begin
        start = 1'b0;
        break;
      end
      check_result("b2b_sweep");
      if (v < 999) begin
        bcd_in = to_bcd(v + 1);
        sb.push_back(ref_conv(bcd_in));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;
    test_reset();
    test_conversion();
    test_invalid();
    test_start_while_busy();
    test_reset_abort();
    sb.delete();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from each digit ≥8). It is the inverse of the board's binary-to-BCD display path: it turns decimal operands entered digit-wise on switches or keypad into the binary operand bus the ALU consumes. It uses a start/busy/done handshake and takes one shift per clock, so it costs little logic on the FPGA.

Parameters:
DIGITS, 3, number of packed BCD digits on bcd_in (digit 0 = bits [3:0], least significant).
BIN_W, 10, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (10 for DIGITS=3).

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request conversion of bcd_in; sampled only in IDLE.
bcd_in  in  4*DIGITS  packed BCD operand; captured on the accepting edge, ignored afterwards.
busy  out  1  high from the accepting edge until the edge that leaves DONE.
done  out  1  one-cycle pulse, result or err valid.
bin_out  out  BIN_W  converted value; holds the last result until the next done.
err  out  1  set with done when any captured digit >9; held until the next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bin_out=0, err=0, shift register=0, counter=0.
- Reset mid-conversion aborts immediately. No done is produced and the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: on a clock edge with start=1, capture bcd_in into a {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_W-1:0]} register with bin_reg=0, and check every digit.
  - If any digit is >9: go to DONE with err_next=1 and result 0. No shifting occurs.
  - Otherwise: go to SHIFT with counter=0.
- SHIFT, one iteration per cycle:
  - Shift the concatenation right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then, for each digit of the shifted bcd_reg, subtract 3 if the digit is ≥8. Shift and correction are one combinational step, registered once per clock.
  - counter increments each iteration; after BIN_W iterations, go to DONE.
- DONE (one cycle): done=1, busy stays 1, bin_out and err are updated in this cycle, then go to IDLE.
- Latency, valid conversion: start accepted at edge k; done high in the cycle after edge k+BIN_W+1 (11 edges for defaults); throughput one conversion per BIN_W+2 cycles.
- Latency, invalid digit: done high after edge k+1.
- start while busy (SHIFT or DONE) is ignored and not queued. The next start is accepted in the cycle after done.
- start held high continuously gives back-to-back conversions, each accepted in IDLE.
- Width rules: bcd_reg digits never underflow (subtract only when ≥8). The final bcd_reg must be 0 for valid input; a nonzero value is a design bug, flagged by an assertion and not by a port.
- err=1 implies bin_out=0.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W=4;
  - localparam helper function for the minimum BIN_W given DIGITS;
  - digit-valid check function (digit ≤ 9).
- One sub-module, bcd_digit_corr: purely combinational 4-bit in/out, subtracts 3 if the input is ≥8. It is instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in bcd2bin_seq.

Test Plan:
- bcd_in=12'h999, start pulse -> done exactly 11 edges later, bin_out=10'd999 (0x3E7), err=0, busy high the whole interval.
- bcd_in=12'h000 -> bin_out=0, err=0. Then bcd_in=12'h409 -> bin_out=10'd409 (0x199).
- bcd_in=12'h1A5 (tens digit=A) -> done one cycle after acceptance, err=1, bin_out=0. A following conversion of 12'h125 gives err=0, bin_out=125.
- Start 12'h512, re-pulse start with 12'h777 at cycle 4 -> only one done, bin_out=512. A fresh start after done yields 777.
- Start 12'h256, drop rst_n at cycle 5 -> busy, done and bin_out go to 0 immediately with no clock. After release, no done appears until a new start.
- start held high with bcd_in sweeping 000..999 against a reference model -> every done matches, with a period of exactly 12 cycles.
